// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI responder and its initiator:
// opcodes, the responder state encoding and a counter width helper.
package qspi_pkg;

    localparam logic [7:0] QSPI_CMD_READ  = 8'hEB;
    localparam logic [7:0] QSPI_CMD_WRITE = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_e;

    // Bits needed to count 0..n-1 nibbles; never less than one bit.
    function automatic int qspi_cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/qspi_responder_if.sv
// Nibble-wide QSPI link between an initiator (master) and the responder (slave).
interface qspi_responder_if;
    logic       cs_n;
    logic [3:0] d_in;
    logic [3:0] d_out;
    logic [3:0] d_oe;
    logic       busy;
    logic       err;

    modport master (
        output cs_n, d_in,
        input  d_out, d_oe, busy, err
    );

    modport slave (
        input  cs_n, d_in,
        output d_out, d_oe, busy, err
    );
endinterface

// File: rtl/qspi_resp_mem.sv
// Byte-wide synchronous RAM backing the responder: one read port with
// one cycle of latency and one write port. Contents are never reset so
// the array can map onto block RAM.
module qspi_resp_mem #(
    parameter int MEM_BYTES = 1024,
    parameter int MAW       = $clog2(MEM_BYTES)
) (
    input  logic           clk,
    input  logic           rd_en,
    input  logic [MAW-1:0] rd_addr,
    output logic [7:0]     rd_data,
    input  logic           we,
    input  logic [MAW-1:0] wr_addr,
    input  logic [7:0]     wr_data
);

    logic [7:0] mem_r [MEM_BYTES];

    // Array write and registered read; rd_data holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/qspi_responder.sv
// QSPI memory responder: decodes quad read / quad write commands one
// nibble per clk and serves them from an internal byte array. Reads
// keep one byte prefetched so the data stream has no bubbles.
module qspi_responder
    import qspi_pkg::*;
#(
    parameter int         AW        = 24,
    parameter int         MEM_BYTES = 1024,
    parameter int         DUMMY     = 4,
    parameter logic [7:0] CMD_READ  = QSPI_CMD_READ,
    parameter logic [7:0] CMD_WRITE = QSPI_CMD_WRITE
) (
    input  logic             clk,
    input  logic             reset,
    qspi_responder_if.slave  bus
);

    localparam int ANIB    = AW / 4;
    localparam int MAW     = $clog2(MEM_BYTES);
    localparam int CNT_MAX = (ANIB > DUMMY) ? ANIB : DUMMY;
    localparam int CW      = qspi_cnt_width(CNT_MAX);

    state_e          state_r;
    state_e          state_s;
    logic [3:0]      cmd_hi_r;
    logic            is_read_r;
    logic [AW-1:0]   addr_r;
    logic [CW-1:0]   cnt_r;
    logic            phase_r;
    logic [3:0]      wr_hi_r;
    logic [7:0]      cur_byte_r;
    logic [3:0]      d_out_r;
    logic [3:0]      d_oe_r;
    logic            busy_r;
    logic            err_r;

    logic [7:0]      cmd_s;
    logic            cmd_ok_s;
    logic            addr_last_s;
    logic            dummy_last_s;
    logic [7:0]      next_cur_s;
    logic            rd_en_s;
    logic            we_s;
    logic [7:0]      rd_data_s;
    logic [MAW-1:0]  mem_addr_s;
    logic [7:0]      wr_data_s;

    qspi_resp_mem #(
        .MEM_BYTES (MEM_BYTES),
        .MAW       (MAW)
    ) u_mem (
        .clk     (clk),
        .rd_en   (rd_en_s),
        .rd_addr (mem_addr_s),
        .rd_data (rd_data_s),
        .we      (we_s),
        .wr_addr (mem_addr_s),
        .wr_data (wr_data_s)
    );

    // State register: reset wins over everything, including a low cs_n.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a high cs_n always returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (bus.cs_n) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = ST_CMD;
                ST_CMD: begin
                    if (cmd_ok_s) begin
                        state_s = ST_ADDR;
                    end else begin
                        state_s = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (addr_last_s) begin
                        state_s = is_read_r ? ST_DUMMY : ST_WDATA;
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_DUMMY: begin
                    if (dummy_last_s) begin
                        state_s = ST_RDATA;
                    end else begin
                        state_s = ST_DUMMY;
                    end
                end
                ST_RDATA:  state_s = ST_RDATA;
                ST_WDATA:  state_s = ST_WDATA;
                ST_IGNORE: state_s = ST_IGNORE;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // Per-cycle controls: opcode decode, memory port strobes and bus outputs.
    always_comb begin
        cmd_s        = {cmd_hi_r, bus.d_in};
        cmd_ok_s     = (cmd_s == CMD_READ) || (cmd_s == CMD_WRITE);
        addr_last_s  = (cnt_r == CW'(ANIB - 1));
        dummy_last_s = (state_r == ST_DUMMY) && (cnt_r == CW'(DUMMY - 1));
        mem_addr_s   = addr_r[MAW-1:0];
        wr_data_s    = {wr_hi_r, bus.d_in};
        // The byte fetched in the first dummy cycle is still on the RAM
        // output during the second one, so take it from there directly.
        if (cnt_r == CW'(1)) begin
            next_cur_s = rd_data_s;
        end else begin
            next_cur_s = cur_byte_r;
        end
        // First two dummy cycles fetch addr and addr+1; each low-nibble
        // cycle of RDATA fetches the byte after the prefetched one.
        rd_en_s = ((state_r == ST_DUMMY) && (cnt_r < CW'(2))) ||
                  ((state_r == ST_RDATA) && phase_r);
        we_s    = (state_r == ST_WDATA) && phase_r && !bus.cs_n && !reset;
        bus.d_out = d_out_r;
        bus.d_oe  = bus.cs_n ? 4'h0 : d_oe_r;
        bus.busy  = busy_r && !bus.cs_n;
        bus.err   = err_r;
    end

    // Datapath registers: command/address capture, counters, read shift buffer, outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_hi_r   <= 4'h0;
            is_read_r  <= 1'b0;
            addr_r     <= '0;
            cnt_r      <= '0;
            phase_r    <= 1'b0;
            wr_hi_r    <= 4'h0;
            cur_byte_r <= 8'h00;
            d_out_r    <= 4'h0;
            d_oe_r     <= 4'h0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else if (bus.cs_n) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
            d_out_r <= 4'h0;
            d_oe_r  <= 4'h0;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    cmd_hi_r <= bus.d_in;
                    cnt_r    <= '0;
                    phase_r  <= 1'b0;
                end
                ST_CMD: begin
                    is_read_r <= (cmd_s == CMD_READ);
                    cnt_r     <= '0;
                    if (!cmd_ok_s) begin
                        err_r <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    addr_r <= {addr_r[AW-5:0], bus.d_in};
                    if (addr_last_s) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DUMMY: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (rd_en_s) begin
                        addr_r[MAW-1:0] <= addr_r[MAW-1:0] + MAW'(1);
                    end
                    if (cnt_r == CW'(1)) begin
                        cur_byte_r <= rd_data_s;
                    end
                    if (dummy_last_s) begin
                        d_out_r <= next_cur_s[7:4];
                        d_oe_r  <= 4'hF;
                        phase_r <= 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (!phase_r) begin
                        d_out_r <= cur_byte_r[3:0];
                        phase_r <= 1'b1;
                    end else begin
                        cur_byte_r      <= rd_data_s;
                        d_out_r         <= rd_data_s[7:4];
                        addr_r[MAW-1:0] <= addr_r[MAW-1:0] + MAW'(1);
                        phase_r         <= 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (!phase_r) begin
                        wr_hi_r <= bus.d_in;
                        phase_r <= 1'b1;
                    end else begin
                        addr_r[MAW-1:0] <= addr_r[MAW-1:0] + MAW'(1);
                        phase_r         <= 1'b0;
                    end
                end
                ST_IGNORE: begin
                    d_oe_r <= 4'h0;
                end
                default: begin
                    d_oe_r <= 4'h0;
                end
            endcase
        end
    end

endmodule
